// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 8-bit CPU control unit.
// Holds the microstep counter and advances it on one-cycle step strobes from the
// clock block. Decodes opcode, next step and latched ALU flags into a registered
// 16-bit control word. A sticky halt goes back to the clock block.
//
// Build option: define MICROSTEP_EARLY_END_EN so that an instruction ends as soon
// as its next microstep (T2 or later) would issue an all-zero control word. With
// the macro undefined, every instruction takes exactly STEPS strobes.
//
// Run state (held in state_q, exported as halt):
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_RUN     | strobes advance step, reload ctrl_word, may latch flags
//   ST_HALTED  | an HLT word was loaded; strobes ignored until clr

module microcode_sequencer #(
   parameter int STEPS    = 5,
   parameter int OPCODE_W = 4
) (
   input  logic                system_clock,
   input  logic                clr,
   input  logic                step_en,
   input  logic [OPCODE_W-1:0] instr,
   input  logic                carry_in,
   input  logic                zero_in,
   output logic [15:0]         ctrl_word,
   output logic [2:0]          step,
   output logic [1:0]          flags,
   output logic                halt
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   // Control word bit masks, bit15..bit0.
   localparam logic [15:0] C_HLT = 16'h8000;
   localparam logic [15:0] C_MI  = 16'h4000;
   localparam logic [15:0] C_RI  = 16'h2000;
   localparam logic [15:0] C_RO  = 16'h1000;
   localparam logic [15:0] C_IO  = 16'h0800;
   localparam logic [15:0] C_II  = 16'h0400;
   localparam logic [15:0] C_AI  = 16'h0200;
   localparam logic [15:0] C_AO  = 16'h0100;
   localparam logic [15:0] C_EO  = 16'h0080;
   localparam logic [15:0] C_SU  = 16'h0040;
   localparam logic [15:0] C_BI  = 16'h0020;
   localparam logic [15:0] C_OI  = 16'h0010;
   localparam logic [15:0] C_CE  = 16'h0008;
   localparam logic [15:0] C_CO  = 16'h0004;
   localparam logic [15:0] C_J   = 16'h0002;
   localparam logic [15:0] C_FI  = 16'h0001;

   // Frequently used microwords.
   localparam logic [15:0] W_FETCH_ADDR = C_CO | C_MI;          // 4004
   localparam logic [15:0] W_FETCH_IR   = C_RO | C_II | C_CE;   // 1408
   localparam logic [15:0] W_OPND_ADDR  = C_IO | C_MI;          // 4800
   localparam logic [15:0] W_JUMP       = C_IO | C_J;           // 0802

   // Opcodes (IR high nibble); anything else decodes as NOP.
   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

   localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

   // Microcode ROM. f is {C,Z} as it will be after the current strobe, so a
   // conditional jump sees flags latched by the very same edge.
   function automatic logic [15:0] rom_word(
      input logic [OPCODE_W-1:0] op,
      input logic [2:0]          t,
      input logic [1:0]          f
   );
      logic [15:0] w;
      w = 16'h0000;
      case (t)
         3'd0: w = W_FETCH_ADDR;
         3'd1: w = W_FETCH_IR;
         3'd2: begin
            if (op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_STA)
               w = W_OPND_ADDR;
            else if (op == OP_LDI)
               w = C_IO | C_AI;
            else if (op == OP_JMP)
               w = W_JUMP;
            else if (op == OP_JC)
               w = f[1] ? W_JUMP : 16'h0000;
            else if (op == OP_JZ)
               w = f[0] ? W_JUMP : 16'h0000;
            else if (op == OP_OUT)
               w = C_AO | C_OI;
            else if (op == OP_HLT)
               w = C_HLT;
            else
               w = 16'h0000;
         end
         3'd3: begin
            if (op == OP_LDA)
               w = C_RO | C_AI;
            else if (op == OP_ADD || op == OP_SUB)
               w = C_RO | C_BI;
            else if (op == OP_STA)
               w = C_AO | C_RI;
            else
               w = 16'h0000;
         end
         3'd4: begin
            if (op == OP_ADD)
               w = C_EO | C_AI | C_FI;
            else if (op == OP_SUB)
               w = C_EO | C_SU | C_AI | C_FI;
            else
               w = 16'h0000;
         end
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   logic [0:0]  state_q;
   logic [2:0]  next_step;
   logic [1:0]  flags_next;
   logic [15:0] rom_next;
   logic [2:0]  load_step;
   logic [15:0] load_word;
   logic        advance;

   assign halt    = (state_q == ST_HALTED);
   assign advance = step_en && (state_q == ST_RUN);

   // Next microstep, flag update and the word the next strobe will load.
   always_comb begin
      next_step  = (step == LAST_STEP) ? 3'd0 : step + 3'd1;
      flags_next = (ctrl_word & C_FI) != 16'h0000 ? {carry_in, zero_in} : flags;
      rom_next   = rom_word(instr, next_step, flags_next);
      load_step  = next_step;
      load_word  = rom_next;
`ifdef MICROSTEP_EARLY_END_EN
      // An empty microstep past the fetch means the instruction is done:
      // jump straight to the next fetch instead of idling through it.
      if (next_step >= 3'd2 && rom_next == 16'h0000) begin
         load_step = 3'd0;
         load_word = W_FETCH_ADDR;
      end
`endif
   end

   // Step, control word, flags and run state all move on the same strobe edge.
   always_ff @(posedge system_clock) begin
      if (clr) begin
         step      <= 3'd0;
         ctrl_word <= W_FETCH_ADDR;
         flags     <= 2'b00;
         state_q   <= ST_RUN;
      end else if (advance) begin
         step      <= load_step;
         ctrl_word <= load_word;
         flags     <= flags_next;
         if ((load_word & C_HLT) != 16'h0000)
            state_q <= ST_HALTED;
      end
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer (default parameters).
// A behavioural model built from per-opcode microprograms tracks the expected
// outputs and is compared to the DUT every cycle; directed literal checks pin
// the model at the interesting points.

module tb_microcode_sequencer;

   localparam int STEPS = 5;

   logic        system_clock = 1'b0;
   logic        clr;
   logic        step_en;
   logic [3:0]  instr;
   logic        carry_in;
   logic        zero_in;
   logic [15:0] ctrl_word;
   logic [2:0]  step;
   logic [1:0]  flags;
   logic        halt;

   int checks = 0;
   int errors = 0;

   microcode_sequencer #(.STEPS(STEPS), .OPCODE_W(4)) dut (
      .system_clock (system_clock),
      .clr          (clr),
      .step_en      (step_en),
      .instr        (instr),
      .carry_in     (carry_in),
      .zero_in      (zero_in),
      .ctrl_word    (ctrl_word),
      .step         (step),
      .flags        (flags),
      .halt         (halt)
   );

   always #5 system_clock = ~system_clock;

   // Microprogram of each opcode as a list of words T0..T4.
   function automatic logic [15:0] model_rom(input int op, input int t, input logic [1:0] f);
      logic [15:0] prog [5];
      prog = '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000};
      case (op)
         1:  begin prog[2] = 16'h4800; prog[3] = 16'h1200; end
         2:  begin prog[2] = 16'h4800; prog[3] = 16'h1020; prog[4] = 16'h0281; end
         3:  begin prog[2] = 16'h4800; prog[3] = 16'h1020; prog[4] = 16'h02C1; end
         4:  begin prog[2] = 16'h4800; prog[3] = 16'h2100; end
         5:  prog[2] = 16'h0A00;
         6:  prog[2] = 16'h0802;
         7:  if (f[1]) prog[2] = 16'h0802;
         8:  if (f[0]) prog[2] = 16'h0802;
         14: prog[2] = 16'h0110;
         15: prog[2] = 16'h8000;
         default: ;
      endcase
      return prog[t];
   endfunction

   int          m_step;
   logic [15:0] m_ctrl;
   logic [1:0]  m_flags;
   logic        m_halt;
   bit          m_valid = 1'b0;

   always @(posedge system_clock) begin
      int          nxt;
      logic [15:0] w;
      if (clr) begin
         m_step  = 0;
         m_ctrl  = 16'h4004;
         m_flags = 2'b00;
         m_halt  = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid && step_en && !m_halt) begin
         if (m_ctrl[0]) m_flags = {carry_in, zero_in};
         nxt = (m_step + 1) % STEPS;
         w   = model_rom(int'(instr), nxt, m_flags);
`ifdef MICROSTEP_EARLY_END_EN
         if (nxt >= 2 && w == 16'h0000) begin
            nxt = 0;
            w   = 16'h4004;
         end
`endif
         m_step = nxt;
         m_ctrl = w;
         if (w[15]) m_halt = 1'b1;
      end
   end

   always @(negedge system_clock) begin
      if (m_valid) begin
         checks++;
         if (ctrl_word !== m_ctrl || step !== m_step[2:0] || flags !== m_flags || halt !== m_halt) begin
            errors++;
            $display("FAIL model t=%0t: got ctrl=%h step=%0d flags=%b halt=%b, want ctrl=%h step=%0d flags=%b halt=%b",
                     $time, ctrl_word, step, flags, halt, m_ctrl, m_step, m_flags, m_halt);
         end
      end
   end

   task automatic strobe();
      step_en = 1'b1;
      @(negedge system_clock);
      step_en = 1'b0;
   endtask

   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) strobe();
   endtask

   task automatic lit(input string name, input logic [15:0] c, input logic [2:0] s,
                      input logic [1:0] f, input logic h);
      checks++;
      if (ctrl_word !== c || step !== s || flags !== f || halt !== h) begin
         errors++;
         $display("FAIL %s: got ctrl=%h step=%0d flags=%b halt=%b, want ctrl=%h step=%0d flags=%b halt=%b",
                  name, ctrl_word, step, flags, halt, c, s, f, h);
      end
   endtask

   // Strobe until the instruction wraps back to T0 (bounded).
   task automatic finish_instr();
      for (int i = 0; i < 8 && m_step != 0; i++) strobe();
      checks++;
      if (step !== 3'd0) begin
         errors++;
         $display("FAIL finish_instr: got step=%0d, want step=0 within 8 strobes", step);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      int ops [5] = '{0, 4, 6, 10, 14};

      clr = 1'b1; step_en = 1'b0; instr = 4'h0; carry_in = 1'b0; zero_in = 1'b0;
      @(negedge system_clock);
      @(negedge system_clock);

      // 1: clr wins over step_en.
      step_en = 1'b1;
      @(negedge system_clock);
      step_en = 1'b0;
      lit("reset_state", 16'h4004, 3'd0, 2'b00, 1'b0);
      clr = 1'b0;

      // 2: LDA walks all five steps and wraps.
      instr = 4'h1;
      strobe(); lit("lda_t1", 16'h1408, 3'd1, 2'b00, 1'b0);
      strobe(); lit("lda_t2", 16'h4800, 3'd2, 2'b00, 1'b0);
      strobe(); lit("lda_t3", 16'h1200, 3'd3, 2'b00, 1'b0);
`ifdef MICROSTEP_EARLY_END_EN
      strobe(); lit("lda_wrap", 16'h4004, 3'd0, 2'b00, 1'b0);
`else
      strobe(); lit("lda_t4", 16'h0000, 3'd4, 2'b00, 1'b0);
      strobe(); lit("lda_wrap", 16'h4004, 3'd0, 2'b00, 1'b0);
`endif

      // 3: ADD sets C, JC taken; then ADD clears flags, JC not taken.
      instr = 4'h2; carry_in = 1'b1; zero_in = 1'b0;
      strobes(3); lit("add_t3", 16'h1020, 3'd3, 2'b00, 1'b0);
      strobe();   lit("add_t4", 16'h0281, 3'd4, 2'b00, 1'b0);
      strobe();   lit("add_flags_c", 16'h4004, 3'd0, 2'b10, 1'b0);
      instr = 4'h7; carry_in = 1'b0;
      strobes(2); lit("jc_taken", 16'h0802, 3'd2, 2'b10, 1'b0);
      finish_instr();

      instr = 4'h2; carry_in = 1'b0; zero_in = 1'b0;
      strobes(5); lit("add_flags_clear", 16'h4004, 3'd0, 2'b00, 1'b0);
      instr = 4'h7;
      strobes(2);
`ifdef MICROSTEP_EARLY_END_EN
      lit("jc_not_taken", 16'h4004, 3'd0, 2'b00, 1'b0);
`else
      lit("jc_not_taken", 16'h0000, 3'd2, 2'b00, 1'b0);
`endif
      finish_instr();

      // 6: SUB 5-5 sets C and Z, JZ taken.
      instr = 4'h3; carry_in = 1'b1; zero_in = 1'b1;
      strobes(4); lit("sub_t4", 16'h02C1, 3'd4, 2'b00, 1'b0);
      strobe();   lit("sub_flags", 16'h4004, 3'd0, 2'b11, 1'b0);
      instr = 4'h8; carry_in = 1'b0; zero_in = 1'b0;
      strobes(2); lit("jz_taken", 16'h0802, 3'd2, 2'b11, 1'b0);
      finish_instr();

      // 5: LDI length depends on the early-end build option.
      instr = 4'h5;
      strobe(); lit("ldi_t1", 16'h1408, 3'd1, 2'b11, 1'b0);
      strobe(); lit("ldi_t2", 16'h0A00, 3'd2, 2'b11, 1'b0);
`ifdef MICROSTEP_EARLY_END_EN
      strobe(); lit("ldi_end", 16'h4004, 3'd0, 2'b11, 1'b0);
`else
      strobe(); lit("ldi_t3", 16'h0000, 3'd3, 2'b11, 1'b0);
      strobe(); lit("ldi_t4", 16'h0000, 3'd4, 2'b11, 1'b0);
      strobe(); lit("ldi_end", 16'h4004, 3'd0, 2'b11, 1'b0);
`endif

      // NOP, STA, JMP, unlisted opcode, OUT: model-checked every cycle.
      for (int k = 0; k < 5; k++) begin
         instr = ops[k][3:0];
         strobe();
         finish_instr();
         @(negedge system_clock);
      end

      // 4: HLT latches, strobes ignored, clr releases.
      instr = 4'hF;
      strobe(); lit("hlt_t1", 16'h1408, 3'd1, 2'b11, 1'b0);
      strobe(); lit("hlt_t2", 16'h8000, 3'd2, 2'b11, 1'b1);
      for (int i = 0; i < 10; i++) begin
         carry_in = i[0]; zero_in = ~i[0];
         instr = i[3:0];
         strobe();
      end
      lit("halt_hold", 16'h8000, 3'd2, 2'b11, 1'b1);
      clr = 1'b1;
      @(negedge system_clock);
      lit("halt_clr", 16'h4004, 3'd0, 2'b00, 1'b0);
      clr = 1'b0;
      instr = 4'h1;
      strobe(); lit("resume", 16'h1408, 3'd1, 2'b00, 1'b0);

      @(negedge system_clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
